// File: rtl/dspl_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Covers the digit code layout, glyph indices and the scheduler state encoding.
package dspl_pkg;

  localparam int CODE_W     = 6;
  localparam int NUM_DIGITS = 8;
  localparam int EN_POS     = 5;
  localparam int CODE_HI    = 4;
  localparam int CODE_LO    = 1;
  localparam int DP_POS     = 0;

  localparam logic [3:0] GLY_P = 4'hA;
  localparam logic [3:0] GLY_S = 4'hD;
  localparam logic [3:0] GLY_U = 4'hF;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    ST_LIVE    = 2'd0,
    ST_MSG_ON  = 2'd1,
    ST_MSG_OFF = 2'd2
  } state_t;

  function automatic code_t make_code(input logic en, input logic [3:0] nib);
    code_t c;
    c                  = '0;
    c[EN_POS]          = en;
    c[CODE_HI:CODE_LO] = nib;
    c[DP_POS]          = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/dspl_ms_tick.sv
// Free-running millisecond prescaler.
// Emits a one-cycle ms_tick on the last count of every MS_COUNT-cycle period.
module dspl_ms_tick #(
  parameter int MS_COUNT = 100000
) (
  input  logic clock,
  input  logic reset,
  output logic ms_tick
);

  localparam int            CW   = (MS_COUNT > 1) ? $clog2(MS_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_COUNT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign ms_tick = (count_reg == LAST);

endmodule

// File: rtl/dspl_msg_sched.sv
// Display content scheduler: live hex value by default, one-shot message client
// gets the display for HOLD_MS milliseconds, optionally blinking.
module dspl_msg_sched
  import dspl_pkg::*;
#(
  parameter int MS_COUNT = 100000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250,
  parameter int LZ_BLANK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] live_val,
  input  logic [7:0]  live_en,
  input  logic        msg_req,
  input  logic [47:0] msg_data,
  input  logic        msg_blink,
  input  logic        msg_cancel,
  output logic        msg_ack,
  output logic        busy,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam logic [15:0] HOLD_INIT  = 16'(HOLD_MS);
  localparam logic [15:0] BLINK_INIT = 16'(BLINK_MS);

  state_t                          state_reg, state_next;
  logic   [15:0]                   hold_cnt_reg, blink_cnt_reg;
  logic   [47:0]                   msg_data_reg;
  logic                            blink_reg;
  logic                            ms_tick;
  logic                            accept, hold_done, blink_flip;
  logic                            ack_next, busy_next;
  logic   [NUM_DIGITS-1:0][CODE_W-1:0] live_code, digit_next, digit_reg;
  logic   [NUM_DIGITS-1:0]         upper_zero;

  dspl_ms_tick #(.MS_COUNT(MS_COUNT)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .ms_tick (ms_tick)
  );

  assign accept     = (state_reg == ST_LIVE) && msg_req;
  // Counters reach zero on the tick where they currently hold 1.
  assign hold_done  = ms_tick && (hold_cnt_reg == 16'd1);
  assign blink_flip = ms_tick && blink_reg && (blink_cnt_reg == 16'd1);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_live
    logic lz;
    assign upper_zero[gi] = (live_val[31:4*gi] == '0);
    assign lz             = (LZ_BLANK != 0) && upper_zero[gi] && (gi != 0);
    assign live_code[gi]  = make_code(live_en[gi] & ~lz, live_val[4*gi +: 4]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_LIVE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Cancel and expiry both beat a blink toggle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LIVE: begin
        if (msg_req) state_next = ST_MSG_ON;
      end
      ST_MSG_ON, ST_MSG_OFF: begin
        if (msg_cancel || hold_done) begin
          state_next = ST_LIVE;
        end else if (blink_flip) begin
          state_next = (state_reg == ST_MSG_ON) ? ST_MSG_OFF : ST_MSG_ON;
        end
      end
      default: state_next = ST_LIVE;
    endcase
  end

  always_comb begin
    ack_next   = accept;
    busy_next  = (state_next != ST_LIVE);
    digit_next = live_code;
    if (state_reg == ST_MSG_ON) begin
      digit_next = msg_data_reg;
    end else if (state_reg == ST_MSG_OFF) begin
      digit_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      msg_data_reg  <= '0;
      blink_reg     <= 1'b0;
    end else if (accept) begin
      hold_cnt_reg  <= HOLD_INIT;
      blink_cnt_reg <= BLINK_INIT;
      msg_data_reg  <= msg_data;
      blink_reg     <= msg_blink;
    end else if ((state_reg != ST_LIVE) && ms_tick) begin
      hold_cnt_reg  <= hold_cnt_reg - 16'd1;
      blink_cnt_reg <= (blink_cnt_reg == 16'd1) ? BLINK_INIT : blink_cnt_reg - 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_ack   <= 1'b0;
      busy      <= 1'b0;
      digit_reg <= '0;
    end else begin
      msg_ack   <= ack_next;
      busy      <= busy_next;
      digit_reg <= digit_next;
    end
  end

  assign d1 = digit_reg[0];
  assign d2 = digit_reg[1];
  assign d3 = digit_reg[2];
  assign d4 = digit_reg[3];
  assign d5 = digit_reg[4];
  assign d6 = digit_reg[5];
  assign d7 = digit_reg[6];
  assign d8 = digit_reg[7];

endmodule

// File: tb/tb_dspl_msg_sched.sv
// Directed bench for dspl_msg_sched with a 4-cycle ms tick, 5 ms hold and 2 ms blink.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_dspl_msg_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] live_val = 32'h0;
  logic [7:0]  live_en = 8'h0;
  logic        msg_req = 1'b0;
  logic [47:0] msg_data = 48'h0;
  logic        msg_blink = 1'b0;
  logic        msg_cancel = 1'b0;
  logic        msg_ack, busy;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [47:0] disp;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] LIVE_A3 = 48'h0000_0000_0D26;
  localparam logic [47:0] MSG_A   = 48'hA5C3_9E71_B24D;
  localparam logic [47:0] MSG_B   = 48'h1234_5678_9ABC;
  localparam logic [47:0] JUNK    = 48'hFFFF_0000_FFFF;

  always #5 clock = ~clock;

  dspl_msg_sched #(
    .MS_COUNT (4),
    .HOLD_MS  (5),
    .BLINK_MS (2),
    .LZ_BLANK (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .live_val   (live_val),
    .live_en    (live_en),
    .msg_req    (msg_req),
    .msg_data   (msg_data),
    .msg_blink  (msg_blink),
    .msg_cancel (msg_cancel),
    .msg_ack    (msg_ack),
    .busy       (busy),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .d5         (d5),
    .d6         (d6),
    .d7         (d7),
    .d8         (d8)
  );

  assign disp = {d8, d7, d6, d5, d4, d3, d2, d1};

  task automatic test_reset();
    live_val = 32'h0000_00A3;
    live_en  = 8'hFF;
    reset    = 1'b1;
    @(negedge clock);
    checks++;
    if (disp !== 48'h0 || busy !== 1'b0 || msg_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: disp=%h busy=%b ack=%b, required disp=0 busy=0 ack=0", disp, busy, msg_ack);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (disp !== LIVE_A3 || busy !== 1'b0 || msg_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_live_a3: disp=%h busy=%b ack=%b, required disp=%h busy=0 ack=0", disp, busy, msg_ack, LIVE_A3);
    end
    $display("reset: disp=%h busy=%b ack=%b", disp, busy, msg_ack);
  endtask

  task automatic test_live_blank();
    logic [31:0] vals [5];
    logic [7:0]  ens  [5];
    logic [47:0] exps [5];
    vals[0] = 32'h0000_0000; ens[0] = 8'hFF; exps[0] = 48'h0000_0000_0020;
    vals[1] = 32'h1000_0000; ens[1] = 8'hFF; exps[1] = {6'h22, {7{6'h20}}};
    vals[2] = 32'h1000_0000; ens[2] = 8'h0F; exps[2] = {6'h02, 6'h00, 6'h00, 6'h00, {4{6'h20}}};
    vals[3] = 32'h0010_0200; ens[3] = 8'hFF; exps[3] = {6'h00, 6'h00, 6'h22, 6'h20, 6'h20, 6'h24, 6'h20, 6'h20};
    vals[4] = 32'h0000_00A3; ens[4] = 8'hFE; exps[4] = {36'h0, 6'h34, 6'h06};
    for (int v = 0; v < 5; v++) begin
      live_val = vals[v];
      live_en  = ens[v];
      @(negedge clock);
      checks++;
      if (disp !== exps[v]) begin
        errors++;
        $display("FAIL live_code[%0d]: val=%h en=%h disp=%h, required %h", v, vals[v], ens[v], disp, exps[v]);
      end
      $display("live: val=%h en=%h disp=%h", vals[v], ens[v], disp);
    end
    live_val = 32'h0000_00A3;
    live_en  = 8'hFF;
    @(negedge clock);
  endtask

  task automatic test_msg_hold();
    bit got_ack = 0;
    int msg_cyc = 0, busy_cyc = 1, extra_ack = 0, odd_cyc = 0;
    msg_data  = MSG_A;
    msg_blink = 1'b0;
    msg_req   = 1'b1;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      @(negedge clock);
      if (msg_ack === 1'b1) got_ack = 1;
    end
    checks++;
    if (!got_ack) begin
      errors++;
      $display("FAIL hold_ack_timeout: ack=%b, required 1 within 10 cycles", msg_ack);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy_with_ack: busy=%b, required 1", busy);
    end
    msg_req  = 1'b0;
    msg_data = JUNK;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (disp !== MSG_A) begin
          errors++;
          $display("FAIL hold_first_msg: disp=%h, required %h", disp, MSG_A);
        end
      end
      if (msg_ack === 1'b1) extra_ack++;
      if (busy === 1'b1) busy_cyc++;
      if (disp === MSG_A) msg_cyc++;
      else if (disp !== LIVE_A3) odd_cyc++;
    end
    checks++;
    if (extra_ack != 0) begin
      errors++;
      $display("FAIL hold_ack_pulse: extra ack cycles=%0d, required 0", extra_ack);
    end
    checks++;
    if (msg_cyc < 17 || msg_cyc > 20) begin
      errors++;
      $display("FAIL hold_length: msg cycles=%0d, required 17..20", msg_cyc);
    end
    checks++;
    if (busy_cyc != msg_cyc) begin
      errors++;
      $display("FAIL hold_busy_length: busy cycles=%0d, required %0d", busy_cyc, msg_cyc);
    end
    checks++;
    if (odd_cyc != 0 || disp !== LIVE_A3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_return_live: odd=%0d disp=%h busy=%b, required odd=0 disp=%h busy=0", odd_cyc, disp, busy, LIVE_A3);
    end
    $display("msg_hold: msg_cycles=%0d busy_cycles=%0d", msg_cyc, busy_cyc);
  endtask

  task automatic test_msg_blink();
    bit got_ack = 0;
    int run_cat [8];
    int run_len [8];
    int nruns = 0, prev = -1, cat;
    for (int i = 0; i < 8; i++) begin
      run_cat[i] = -1;
      run_len[i] = 0;
    end
    msg_data  = MSG_A;
    msg_blink = 1'b1;
    msg_req   = 1'b1;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      @(negedge clock);
      if (msg_ack === 1'b1) got_ack = 1;
    end
    checks++;
    if (!got_ack) begin
      errors++;
      $display("FAIL blink_ack_timeout: ack=%b, required 1 within 10 cycles", msg_ack);
    end
    msg_req   = 1'b0;
    msg_blink = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (disp === MSG_A) cat = 1;
      else if (disp === 48'h0) cat = 2;
      else if (disp === LIVE_A3) cat = 0;
      else cat = 3;
      if (cat != prev) begin
        if (nruns < 8) begin
          run_cat[nruns] = cat;
          run_len[nruns] = 1;
        end
        nruns++;
        prev = cat;
      end else if (nruns >= 1 && nruns <= 8) begin
        run_len[nruns-1]++;
      end
    end
    checks++;
    if (nruns != 4) begin
      errors++;
      $display("FAIL blink_run_count: runs=%0d, required 4 (msg, blank, msg, live)", nruns);
    end else begin
      checks++;
      if (run_cat[0] != 1 || run_len[0] < 5 || run_len[0] > 8) begin
        errors++;
        $display("FAIL blink_first_on: cat=%0d len=%0d, required cat=1 len=5..8", run_cat[0], run_len[0]);
      end
      checks++;
      if (run_cat[1] != 2 || run_len[1] != 8) begin
        errors++;
        $display("FAIL blink_off: cat=%0d len=%0d, required cat=2 len=8", run_cat[1], run_len[1]);
      end
      checks++;
      if (run_cat[2] != 1 || run_len[2] != 4) begin
        errors++;
        $display("FAIL blink_second_on: cat=%0d len=%0d, required cat=1 len=4", run_cat[2], run_len[2]);
      end
      checks++;
      if (run_cat[3] != 0) begin
        errors++;
        $display("FAIL blink_return_live: cat=%0d, required 0", run_cat[3]);
      end
    end
    $display("msg_blink: runs=%0d lens=%0d/%0d/%0d/%0d", nruns, run_len[0], run_len[1], run_len[2], run_len[3]);
  endtask

  task automatic test_back_to_back();
    bit got_ack = 0;
    int fall_cyc = -1, ack_cyc = -1;
    msg_data  = MSG_A;
    msg_blink = 1'b0;
    msg_req   = 1'b1;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      @(negedge clock);
      if (msg_ack === 1'b1) got_ack = 1;
    end
    checks++;
    if (!got_ack) begin
      errors++;
      $display("FAIL b2b_first_ack_timeout: ack=%b, required 1 within 10 cycles", msg_ack);
    end
    msg_data = MSG_B;
    for (int k = 1; k <= 40 && ack_cyc < 0; k++) begin
      @(negedge clock);
      if (busy === 1'b0 && fall_cyc < 0) fall_cyc = k;
      if (msg_ack === 1'b1) ack_cyc = k;
    end
    msg_req = 1'b0;
    checks++;
    if (ack_cyc < 0 || fall_cyc < 0 || ack_cyc - fall_cyc < 1 || ack_cyc - fall_cyc > 2) begin
      errors++;
      $display("FAIL b2b_ack_gap: busy fell at %0d ack at %0d, required ack 1..2 cycles after busy fall", fall_cyc, ack_cyc);
    end
    @(negedge clock);
    checks++;
    if (disp !== MSG_B || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_new_data: disp=%h busy=%b, required disp=%h busy=1", disp, busy, MSG_B);
    end
    for (int k = 0; k < 30 && busy === 1'b1; k++) @(negedge clock);
    @(negedge clock);
    $display("back_to_back: fall=%0d ack=%0d", fall_cyc, ack_cyc);
  endtask

  task automatic test_cancel();
    bit got_ack = 0;
    msg_data  = MSG_A;
    msg_blink = 1'b0;
    msg_req   = 1'b1;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      @(negedge clock);
      if (msg_ack === 1'b1) got_ack = 1;
    end
    msg_req = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || disp !== MSG_A) begin
      errors++;
      $display("FAIL cancel_pre: busy=%b disp=%h, required busy=1 disp=%h", busy, disp, MSG_A);
    end
    msg_cancel = 1'b1;
    @(negedge clock);
    msg_cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy: busy=%b, required 0", busy);
    end
    @(negedge clock);
    checks++;
    if (disp !== LIVE_A3) begin
      errors++;
      $display("FAIL cancel_live: disp=%h, required %h", disp, LIVE_A3);
    end
    $display("cancel: busy=%b disp=%h", busy, disp);
  endtask

  task automatic test_reset_mid_msg();
    bit got_ack = 0, in_off = 0;
    msg_data  = MSG_A;
    msg_blink = 1'b1;
    msg_req   = 1'b1;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      @(negedge clock);
      if (msg_ack === 1'b1) got_ack = 1;
    end
    msg_req = 1'b0;
    for (int k = 0; k < 30 && !in_off; k++) begin
      @(negedge clock);
      if (busy === 1'b1 && disp === 48'h0) in_off = 1;
    end
    checks++;
    if (!in_off) begin
      errors++;
      $display("FAIL rst_wait_off: busy=%b disp=%h, required blank display while busy", busy, disp);
    end
    msg_req  = 1'b1;
    msg_data = MSG_B;
    reset    = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || msg_ack !== 1'b0 || disp !== 48'h0) begin
      errors++;
      $display("FAIL rst_immediate: busy=%b ack=%b disp=%h, required 0/0/0", busy, msg_ack, disp);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (msg_ack !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_reserve: ack=%b busy=%b, required ack=1 busy=1", msg_ack, busy);
    end
    msg_req = 1'b0;
    @(negedge clock);
    checks++;
    if (disp !== MSG_B) begin
      errors++;
      $display("FAIL rst_new_data: disp=%h, required %h", disp, MSG_B);
    end
    $display("reset_mid_msg: ack=%b disp=%h", msg_ack, disp);
  endtask

  initial begin
    test_reset();
    test_live_blank();
    test_msg_hold();
    test_msg_blink();
    test_back_to_back();
    test_cancel();
    test_reset_mid_msg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
